ex_mac_stage: RTL and testbench

//  Execute stage directly downstream of the ID/EX pipeline register. Computes
//  ALU1 = A op (B | SignImm), then ALU2 = ALU1 op C (accumulate/ReLU), and

---
 rtl/ex_mac_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_ex_mac_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mac_stage.sv
// ex_mac_stage: EX stage, ALU1 -> ALU2 chain into the EX/MEM register, with an iterative shift-add MUL.
// Build macro SAT_MUL_EN: saturate MUL results on signed overflow (default build wraps).
module ex_mac_stage #(
  parameter int BUS_WIDTH      = 32,
  parameter int ALU_FUNCT_BITS = 3,
  parameter int REGISTER_SIZE  = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ValidE,
  input  logic [BUS_WIDTH-1:0]      Src1A,
  input  logic [BUS_WIDTH-1:0]      Src1B,
  input  logic [BUS_WIDTH-1:0]      Src1C,
  input  logic [BUS_WIDTH-1:0]      SignImm,
  input  logic                      ALU1Src,
  input  logic [ALU_FUNCT_BITS-1:0] ALU1Cntrl,
  input  logic [ALU_FUNCT_BITS-1:0] ALU2Cntrl,
  input  logic                      RegDst,
  input  logic [REGISTER_SIZE-1:0]  Rt,
  input  logic [REGISTER_SIZE-1:0]  Rd,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemtoReg,
  output logic                      StallE,
  output logic                      ValidM,
  output logic [BUS_WIDTH-1:0]      ALUOutM,
  output logic [BUS_WIDTH-1:0]      WriteDataM,
  output logic [REGISTER_SIZE-1:0]  WriteRegM,
  output logic                      RegWriteM,
  output logic                      MemWriteM,
  output logic                      MemtoRegM
);
  localparam int BW    = BUS_WIDTH;
  localparam int CNT_W = $clog2(BW);
  localparam int SH_W  = $clog2(BW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW - 1);

  localparam logic [ALU_FUNCT_BITS-1:0] A1_ADD  = ALU_FUNCT_BITS'(0);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_SUB  = ALU_FUNCT_BITS'(1);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_AND  = ALU_FUNCT_BITS'(2);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_OR   = ALU_FUNCT_BITS'(3);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_SLT  = ALU_FUNCT_BITS'(4);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_MUL  = ALU_FUNCT_BITS'(5);
  localparam logic [ALU_FUNCT_BITS-1:0] A1_SRA  = ALU_FUNCT_BITS'(6);
  localparam logic [ALU_FUNCT_BITS-1:0] A2_ADD  = ALU_FUNCT_BITS'(1);
  localparam logic [ALU_FUNCT_BITS-1:0] A2_SUB  = ALU_FUNCT_BITS'(2);
  localparam logic [ALU_FUNCT_BITS-1:0] A2_MAX  = ALU_FUNCT_BITS'(3);
  localparam logic [ALU_FUNCT_BITS-1:0] A2_RELU = ALU_FUNCT_BITS'(4);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  function automatic logic [BW-1:0] alu1_f(input logic [ALU_FUNCT_BITS-1:0] op,
                                           input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    case (op)
      A1_ADD:  r = a + b;
      A1_SUB:  r = a - b;
      A1_AND:  r = a & b;
      A1_OR:   r = a | b;
      A1_SLT:  r = BW'($signed(a) < $signed(b));
      A1_SRA:  r = $signed(a) >>> b[SH_W-1:0];
      default: r = b;  // pass op2; MUL never reaches the single-cycle path
    endcase
    return r;
  endfunction

  function automatic logic [BW-1:0] alu2_f(input logic [ALU_FUNCT_BITS-1:0] op,
                                           input logic [BW-1:0] r, input logic [BW-1:0] c);
    logic [BW-1:0] y;
    case (op)
      A2_ADD:  y = r + c;
      A2_SUB:  y = r - c;
      A2_MAX:  y = ($signed(r) > $signed(c)) ? r : c;
      A2_RELU: y = r[BW-1] ? '0 : r;
      default: y = r;
    endcase
    return y;
  endfunction

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [2*BW-1:0]            mcand_q, mcand_d;
  logic [2*BW-1:0]            acc_q, acc_d;
  logic [BW-1:0]              mplier_q, mplier_d;
  logic                       neg_q, neg_d;
  logic [BW-1:0]              c_q, c_d;
  logic [ALU_FUNCT_BITS-1:0]  alu2_ctl_q, alu2_ctl_d;
  logic [BW-1:0]              wdata_q, wdata_d;
  logic [REGISTER_SIZE-1:0]   wreg_q, wreg_d;
  logic                       rw_q, rw_d, mw_q, mw_d, mtr_q, mtr_d;
  logic                       valid_m_q, valid_m_d;
  logic [BW-1:0]              alu_out_m_q, alu_out_m_d;
  logic [BW-1:0]              write_data_m_q, write_data_m_d;
  logic [REGISTER_SIZE-1:0]   write_reg_m_q, write_reg_m_d;
  logic                       reg_write_m_q, reg_write_m_d;
  logic                       mem_write_m_q, mem_write_m_d;
  logic                       mem_to_reg_m_q, mem_to_reg_m_d;
  logic                       stall;
  logic [BW-1:0]              op2, abs_a, abs_b, mul_res;
  logic [REGISTER_SIZE-1:0]   sel_reg;

  assign op2     = ALU1Src ? SignImm : Src1B;
  assign abs_a   = Src1A[BW-1] ? -Src1A : Src1A;
  assign abs_b   = op2[BW-1] ? -op2 : op2;
  assign sel_reg = RegDst ? Rd : Rt;

`ifdef SAT_MUL_EN
  logic [2*BW-1:0] prod_full;
  logic            ovf;
  assign prod_full = neg_q ? -acc_q : acc_q;
  // Overflow when the bits above the result's sign are not a pure sign extension.
  assign ovf     = !((&prod_full[2*BW-1:BW-1]) || !(|prod_full[2*BW-1:BW-1]));
  assign mul_res = !ovf ? prod_full[BW-1:0]
                 : (prod_full[2*BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}});
`else
  assign mul_res = neg_q ? -acc_q[BW-1:0] : acc_q[BW-1:0];
`endif

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    mcand_d        = mcand_q;
    acc_d          = acc_q;
    mplier_d       = mplier_q;
    neg_d          = neg_q;
    c_d            = c_q;
    alu2_ctl_d     = alu2_ctl_q;
    wdata_d        = wdata_q;
    wreg_d         = wreg_q;
    rw_d           = rw_q;
    mw_d           = mw_q;
    mtr_d          = mtr_q;
    stall          = 1'b0;
    // Default is a bubble: kill valid and write enables, hold the data fields.
    valid_m_d      = 1'b0;
    reg_write_m_d  = 1'b0;
    mem_write_m_d  = 1'b0;
    alu_out_m_d    = alu_out_m_q;
    write_data_m_d = write_data_m_q;
    write_reg_m_d  = write_reg_m_q;
    mem_to_reg_m_d = mem_to_reg_m_q;
    case (state_q)
      S_IDLE: begin
        if (ValidE && ALU1Cntrl == A1_MUL) begin
          stall      = 1'b1;
          state_d    = S_MUL;
          count_d    = '0;
          mcand_d    = {{BW{1'b0}}, abs_a};
          mplier_d   = abs_b;
          acc_d      = '0;
          neg_d      = Src1A[BW-1] ^ op2[BW-1];
          c_d        = Src1C;
          alu2_ctl_d = ALU2Cntrl;
          wdata_d    = Src1B;
          wreg_d     = sel_reg;
          rw_d       = RegWrite;
          mw_d       = MemWrite;
          mtr_d      = MemtoReg;
        end else if (ValidE) begin
          valid_m_d      = 1'b1;
          alu_out_m_d    = alu2_f(ALU2Cntrl, alu1_f(ALU1Cntrl, Src1A, op2), Src1C);
          write_data_m_d = Src1B;
          write_reg_m_d  = sel_reg;
          reg_write_m_d  = RegWrite;
          mem_write_m_d  = MemWrite;
          mem_to_reg_m_d = MemtoReg;
        end
      end
      S_MUL: begin
        stall    = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == CNT_LAST) begin
          state_d = S_DONE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d        = S_IDLE;
        valid_m_d      = 1'b1;
        alu_out_m_d    = alu2_f(alu2_ctl_q, mul_res, c_q);
        write_data_m_d = wdata_q;
        write_reg_m_d  = wreg_q;
        reg_write_m_d  = rw_q;
        mem_write_m_d  = mw_q;
        mem_to_reg_m_d = mtr_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      mcand_q        <= '0;
      acc_q          <= '0;
      mplier_q       <= '0;
      neg_q          <= 1'b0;
      c_q            <= '0;
      alu2_ctl_q     <= '0;
      wdata_q        <= '0;
      wreg_q         <= '0;
      rw_q           <= 1'b0;
      mw_q           <= 1'b0;
      mtr_q          <= 1'b0;
      valid_m_q      <= 1'b0;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_reg_m_q  <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      mcand_q        <= mcand_d;
      acc_q          <= acc_d;
      mplier_q       <= mplier_d;
      neg_q          <= neg_d;
      c_q            <= c_d;
      alu2_ctl_q     <= alu2_ctl_d;
      wdata_q        <= wdata_d;
      wreg_q         <= wreg_d;
      rw_q           <= rw_d;
      mw_q           <= mw_d;
      mtr_q          <= mtr_d;
      valid_m_q      <= valid_m_d;
      alu_out_m_q    <= alu_out_m_d;
      write_data_m_q <= write_data_m_d;
      write_reg_m_q  <= write_reg_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
    end
  end

  // Stall is combinational from the issue cycle; reset forces it low.
  assign StallE     = stall & ~RST;
  assign ValidM     = valid_m_q;
  assign ALUOutM    = alu_out_m_q;
  assign WriteDataM = write_data_m_q;
  assign WriteRegM  = write_reg_m_q;
  assign RegWriteM  = reg_write_m_q;
  assign MemWriteM  = mem_write_m_q;
  assign MemtoRegM  = mem_to_reg_m_q;
endmodule

// File: tb/tb_ex_mac_stage.sv
// tb_ex_mac_stage: directed and randomized checks of ex_mac_stage against an arithmetic reference model.
module tb_ex_mac_stage;
  localparam int BW = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ValidE;
  logic [31:0] Src1A, Src1B, Src1C, SignImm;
  logic        ALU1Src;
  logic [2:0]  ALU1Cntrl, ALU2Cntrl;
  logic        RegDst;
  logic [5:0]  Rt, Rd;
  logic        RegWrite, MemWrite, MemtoReg;
  logic        StallE, ValidM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [5:0]  WriteRegM;
  logic        RegWriteM, MemWriteM, MemtoRegM;

  ex_mac_stage dut (
    .CLK(CLK), .RST(RST), .ValidE(ValidE), .Src1A(Src1A), .Src1B(Src1B), .Src1C(Src1C),
    .SignImm(SignImm), .ALU1Src(ALU1Src), .ALU1Cntrl(ALU1Cntrl), .ALU2Cntrl(ALU2Cntrl),
    .RegDst(RegDst), .Rt(Rt), .Rd(Rd), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .StallE(StallE), .ValidM(ValidM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Expected EX/MEM contents.
  logic        m_valid, m_rw, m_mw, m_mtr;
  logic [31:0] m_alu, m_wdata;
  logic [5:0]  m_wreg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_m(input string t);
    check({t, ".valid"}, 32'(ValidM), 32'(m_valid));
    check({t, ".alu"}, ALUOutM, m_alu);
    check({t, ".wdata"}, WriteDataM, m_wdata);
    check({t, ".wreg"}, 32'(WriteRegM), 32'(m_wreg));
    check({t, ".rw"}, 32'(RegWriteM), 32'(m_rw));
    check({t, ".mw"}, 32'(MemWriteM), 32'(m_mw));
    check({t, ".mtr"}, 32'(MemtoRegM), 32'(m_mtr));
  endtask

  function automatic logic [31:0] ref_alu1(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return (sa < sb) ? 32'd1 : 32'd0;
      5: begin
        p = longint'(sa) * longint'(sb);
`ifdef SAT_MUL_EN
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
        return p[31:0];
      end
      6: return sa >>> b[4:0];
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu2(input int op, input logic [31:0] r, input logic [31:0] c);
    int sr, sc;
    sr = r;
    sc = c;
    case (op)
      1: return r + c;
      2: return r - c;
      3: return (sr > sc) ? r : c;
      4: return (sr < 0) ? 32'd0 : r;
      default: return r;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] o1, input logic [2:0] o2,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] imm, input logic src, input logic rdst,
                       input logic [5:0] rt, input logic [5:0] rd,
                       input logic rw, input logic mw, input logic mtr);
    ValidE = v; ALU1Cntrl = o1; ALU2Cntrl = o2; Src1A = a; Src1B = b; Src1C = c;
    SignImm = imm; ALU1Src = src; RegDst = rdst; Rt = rt; Rd = rd;
    RegWrite = rw; MemWrite = mw; MemtoReg = mtr;
  endtask

  task automatic scramble();
    drive(1'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run_instr(input logic v, input logic [2:0] o1, input logic [2:0] o2,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] imm, input logic src, input logic rdst,
                           input logic [5:0] rt, input logic [5:0] rd,
                           input logic rw, input logic mw, input logic mtr);
    logic [31:0] opnd2, res;
    int stall_cnt;
    bit bubble_ok;
    @(negedge CLK);
    drive(v, o1, o2, a, b, c, imm, src, rdst, rt, rd, rw, mw, mtr);
    opnd2 = src ? imm : b;
    res = ref_alu2(int'(o2), ref_alu1(int'(o1), a, opnd2), c);
    #1;
    n_txn++;
    if (!(v && o1 == 3'd5)) begin
      check("stall_single", 32'(StallE), 32'd0);
      @(posedge CLK);
      #1;
      m_valid = v;
      m_rw = v & rw;
      m_mw = v & mw;
      if (v) begin
        m_alu = res; m_wdata = b; m_wreg = rdst ? rd : rt; m_mtr = mtr;
      end
      check_m("single");
    end else begin
      stall_cnt = 0;
      bubble_ok = 1'b1;
      for (int k = 0; k <= BW; k++) begin
        if (StallE) stall_cnt++;
        @(posedge CLK);
        #1;
        if (ValidM !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) bubble_ok = 1'b0;
        @(negedge CLK);
        scramble();
        #1;
      end
      check("mul.stall_cycles", 32'(stall_cnt), 32'(BW + 1));
      check("mul.bubble", 32'(bubble_ok), 32'd1);
      check("mul.done_stall", 32'(StallE), 32'd0);
      @(posedge CLK);
      #1;
      m_valid = 1'b1; m_alu = res; m_wdata = b; m_wreg = rdst ? rd : rt;
      m_rw = rw; m_mw = mw; m_mtr = mtr;
      check_m("mul");
    end
    $display("txn %0d: v=%0b op1=%0d op2=%0d a=%h opnd2=%h c=%h exp=%h got=%h validM=%0b",
             n_txn, v, o1, o2, a, opnd2, c, m_alu, ALUOutM, ValidM);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_alu = 0; m_wdata = 0; m_wreg = 0;
  endtask

  initial begin
    logic [31:0] a, b, c, imm;
    logic [2:0] o1;
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_m("reset");
    check("reset.stall", 32'(StallE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_instr(1, 3'd0, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1, 6'd3, 6'd9, 1, 0, 0);
    check("add.lit", ALUOutM, 32'd12);
    check("add.wreg_lit", 32'(WriteRegM), 32'd9);
    run_instr(1, 3'd5, 3'd1, -32'sd3, 32'h1234_5678, 32'd100, 32'd7, 1, 1, 6'd1, 6'd2, 1, 0, 1);
    check("mul_acc.lit", ALUOutM, 32'd79);
    run_instr(1, 3'd5, 3'd0, 32'h4000_0000, 32'd4, 32'd0, 32'd0, 0, 0, 6'd4, 6'd5, 1, 0, 0);
`ifdef SAT_MUL_EN
    check("mul_ovf.lit", ALUOutM, 32'h7FFF_FFFF);
`else
    check("mul_ovf.lit", ALUOutM, 32'h0000_0000);
`endif
    run_instr(0, 3'd0, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 0, 0, 6'd7, 6'd8, 1, 1, 1);
    check("bubble.rw_lit", 32'(RegWriteM), 32'd0);
    check("bubble.mw_lit", 32'(MemWriteM), 32'd0);
    run_instr(1, 3'd1, 3'd4, 32'd3, 32'd10, 32'd0, 32'd0, 0, 1, 6'd0, 6'd11, 1, 0, 0);
    check("sub_relu.lit", ALUOutM, 32'd0);
    run_instr(1, 3'd4, 3'd0, -32'sd1, 32'd2, 32'd0, 32'd0, 0, 1, 6'd0, 6'd12, 1, 0, 0);
    check("slt.lit", ALUOutM, 32'd1);

    // Reset during the 10th multiply cycle.
    @(negedge CLK);
    drive(1, 3'd5, 3'd0, 32'd123, 32'd456, 32'd0, 32'd0, 0, 1, 6'd1, 6'd13, 1, 1, 1);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    ValidE = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    check_m("midmul_reset");
    check("midmul_reset.stall", 32'(StallE), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("after_reset.idle", 32'(StallE), 32'd0);
    run_instr(1, 3'd0, 3'd0, 32'd20, 32'd22, 32'd0, 32'd0, 0, 1, 6'd0, 6'd14, 1, 0, 0);
    check("after_reset.add_lit", ALUOutM, 32'd42);

    for (int i = 0; i < 60; i++) begin
      o1 = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom);
      a = ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      c = $urandom;
      imm = 32'($signed(16'($urandom)));
      run_instr(1'($urandom_range(0, 7) != 0), o1, 3'($urandom), a, b, c, imm,
                1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
